aes_key_sched_ctrl: RTL and testbench

//  Loads round keys into the AES-128 round pipeline (10 round stages + initial AddRoundKey stage).

---
 rtl/aes_pkg.sv | 54 +++++
 rtl/aes_key_sched_ctrl_if.sv | 36 +++
 rtl/aes_sub_word.sv | 12 +
 rtl/aes_key_sched_ctrl.sv | 107 ++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule FSM states, S-box table and round-key step helper.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_KEY_W = 128;
  localparam int AES_NS    = AES_NR + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, EXPAND, DONE} ks_state_t;

  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Rounds past the last expansion step never consume a constant.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    if (r < 4'(AES_NR)) return RCON[r];
    return 8'h00;
  endfunction

  function automatic logic [AES_KEY_W-1:0] next_round_key(input logic [AES_KEY_W-1:0] k,
                                                          input logic [31:0] sub_rot,
                                                          input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Key-load bus between the key scheduler and its environment; zeroize exists only
// when AES_KEY_ZEROIZE_EN is defined.
interface aes_key_sched_ctrl_if;
  import aes_pkg::*;

  logic [AES_KEY_W-1:0] key_in;
  logic                 key_valid;
  logic                 key_ready;
  logic                 pipe_empty;
  logic                 issue_block;
  logic [AES_KEY_W-1:0] rk_bus;
  logic [AES_NS-1:0]    set_key;
  logic [AES_NS-1:0]    set_inv_key;
  logic                 load_done;
  logic                 key_loaded;
`ifdef AES_KEY_ZEROIZE_EN
  logic                 zeroize;
`endif

  modport master (
`ifdef AES_KEY_ZEROIZE_EN
    output zeroize,
`endif
    output key_in, key_valid, pipe_empty,
    input  key_ready, issue_block, rk_bus, set_key, set_inv_key, load_done, key_loaded
  );

  modport slave (
`ifdef AES_KEY_ZEROIZE_EN
    input  zeroize,
`endif
    input  key_in, key_valid, pipe_empty,
    output key_ready, issue_block, rk_bus, set_key, set_inv_key, load_done, key_loaded
  );

endinterface

// File: rtl/aes_sub_word.sv
// Combinational AES SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                   sbox(word_i[15:8]),  sbox(word_i[7:0])};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: drains the round pipeline, then broadcasts one round key
// per cycle with one-hot stage strobes. Optional zeroize port under AES_KEY_ZEROIZE_EN.
module aes_key_sched_ctrl
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  aes_key_sched_ctrl_if.slave bus
);

  localparam logic [AES_NS-1:0] ONE_HOT = AES_NS'(1);

  ks_state_t            state_q;
  logic [3:0]           rnd_q;
  logic [AES_KEY_W-1:0] key_q, key_d;
  logic [AES_KEY_W-1:0] rk_bus_q;
  logic [AES_NS-1:0]    set_key_q, set_inv_key_q;
  logic                 load_done_q, key_loaded_q, issue_block_q, key_ready_q;
  logic [31:0]          sub_rot;
  logic                 accept;

  aes_sub_word u_sub_word (
    .word_i ({key_q[23:0], key_q[31:24]}),
    .word_o (sub_rot)
  );

  assign key_d  = next_round_key(key_q, sub_rot, rcon(rnd_q));
  // key_ready_q is only ever set while idle, so it alone qualifies the handshake.
  assign accept = bus.key_valid && key_ready_q;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rnd_q         <= '0;
      key_q         <= '0;
      rk_bus_q      <= '0;
      set_key_q     <= '0;
      set_inv_key_q <= '0;
      load_done_q   <= 1'b0;
      key_loaded_q  <= 1'b0;
      issue_block_q <= 1'b0;
      key_ready_q   <= 1'b0;
    end
`ifdef AES_KEY_ZEROIZE_EN
    else if (bus.zeroize) begin
      state_q       <= IDLE;
      rnd_q         <= '0;
      key_q         <= '0;
      rk_bus_q      <= '0;
      set_key_q     <= '1;
      set_inv_key_q <= '1;
      load_done_q   <= 1'b0;
      key_loaded_q  <= 1'b0;
      issue_block_q <= 1'b0;
      key_ready_q   <= 1'b0;
    end
`endif
    else begin
      set_key_q     <= '0;
      set_inv_key_q <= '0;
      load_done_q   <= 1'b0;
      key_ready_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q       <= DRAIN;
            key_q         <= bus.key_in;
            issue_block_q <= 1'b1;
            key_loaded_q  <= 1'b0;
          end else begin
            key_ready_q   <= 1'b1;
          end
        end
        DRAIN: begin
          if (bus.pipe_empty) begin
            state_q <= EXPAND;
            rnd_q   <= '0;
          end
        end
        EXPAND: begin
          rk_bus_q      <= key_q;
          set_key_q     <= ONE_HOT << rnd_q;
          set_inv_key_q <= ONE_HOT << (4'(AES_NR) - rnd_q);
          key_q         <= key_d;
          if (rnd_q == 4'(AES_NR)) state_q <= DONE;
          else                     rnd_q   <= rnd_q + 4'd1;
        end
        DONE: begin
          state_q       <= IDLE;
          load_done_q   <= 1'b1;
          key_loaded_q  <= 1'b1;
          issue_block_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.key_ready   = key_ready_q;
  assign bus.issue_block = issue_block_q;
  assign bus.rk_bus      = rk_bus_q;
  assign bus.set_key     = set_key_q;
  assign bus.set_inv_key = set_inv_key_q;
  assign bus.load_done   = load_done_q;
  assign bus.key_loaded  = key_loaded_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: known-answer table, corner sequences and
// random keys against a word-level FIPS-197 key-expansion model.
module tb_aes_key_sched_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_key_sched_ctrl_if bus ();

  aes_key_sched_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  typedef struct {
    logic [127:0] key;
    int           hold;
    logic [127:0] rk1;
    logic [127:0] rk10;
  } vec_t;

  vec_t         vecs [3];
  logic [7:0]   sbox_tbl [0:255];
  logic [127:0] mdl_rk [0:10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] a = a_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xtime(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tbl[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
        t ^= {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mdl_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // abort_kind: 0 none, 1 rst after strobe abort_r, 2 zeroize after strobe abort_r.
  task automatic do_load(input logic [127:0] key, input int hold, input bit keep_valid,
                         input logic [127:0] next_key, input bit rand_pe,
                         input int abort_r, input int abort_kind,
                         output logic [127:0] got1, output logic [127:0] got10);
    int n = 0;
    got1  = '0;
    got10 = '0;
    build_model(key);
    while (bus.key_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (bus.key_ready !== 1'b1) begin
      check("ready_timeout", {127'd0, bus.key_ready}, 128'd1);
      return;
    end
    bus.key_in     = key;
    bus.key_valid  = 1'b1;
    bus.pipe_empty = (hold == 0);
    tick();
    if (keep_valid) bus.key_in = next_key;
    else            bus.key_valid = 1'b0;
    check("accept_ready", bus.key_ready, 0);
    check("accept_block", bus.issue_block, 1);
    check("accept_loaded", bus.key_loaded, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("drain_strobe", bus.set_key, 0);
      check("drain_block", bus.issue_block, 1);
    end
    bus.pipe_empty = 1'b1;
    tick();
    check("pre_strobe", {bus.set_key, bus.set_inv_key}, 0);
    for (int r = 0; r <= 10; r++) begin
      if (rand_pe) bus.pipe_empty = 1'($urandom_range(0, 1));
      tick();
      check($sformatf("set_key_r%0d", r), bus.set_key, 11'd1 << r);
      check($sformatf("set_inv_r%0d", r), bus.set_inv_key, 11'd1 << (10 - r));
      check($sformatf("rk_bus_r%0d", r), bus.rk_bus, mdl_rk[r]);
      check("expand_flags", {bus.issue_block, bus.load_done, bus.key_ready, bus.key_loaded}, 4'b1000);
      if (r == 1)  got1  = bus.rk_bus;
      if (r == 10) got10 = bus.rk_bus;
      if (r == abort_r && abort_kind == 1) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_strobes", {bus.set_key, bus.set_inv_key}, 0);
        check("rst_rk_bus", bus.rk_bus, 0);
        check("rst_flags", {bus.issue_block, bus.load_done, bus.key_ready, bus.key_loaded}, 0);
        tick();
        check("rst_ready_after", {bus.key_ready, bus.key_loaded, bus.set_key}, {2'b10, 11'd0});
        bus.pipe_empty = 1'b1;
        return;
      end
`ifdef AES_KEY_ZEROIZE_EN
      if (r == abort_r && abort_kind == 2) begin
        bus.zeroize = 1'b1;
        tick();
        bus.zeroize = 1'b0;
        check("zero_rk_bus", bus.rk_bus, 0);
        check("zero_set_key", bus.set_key, 11'h7ff);
        check("zero_set_inv", bus.set_inv_key, 11'h7ff);
        check("zero_flags", {bus.load_done, bus.key_loaded, bus.issue_block}, 0);
        tick();
        check("zero_after", {bus.key_ready, bus.set_key, bus.set_inv_key}, {1'b1, 22'd0});
        bus.pipe_empty = 1'b1;
        return;
      end
`endif
    end
    bus.pipe_empty = 1'b1;
    tick();
    check("done_strobe", {bus.set_key, bus.set_inv_key}, 0);
    check("done_flags", {bus.load_done, bus.key_loaded, bus.issue_block, bus.key_ready}, 4'b1100);
    tick();
    check("idle_flags", {bus.load_done, bus.key_loaded, bus.issue_block, bus.key_ready}, 4'b0101);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] g1, g10, kb;
    build_sbox();
    bus.key_in     = '0;
    bus.key_valid  = 1'b0;
    bus.pipe_empty = 1'b1;
`ifdef AES_KEY_ZEROIZE_EN
    bus.zeroize    = 1'b0;
`endif

    rst = 1'b1;
    tick();
    check("reset_rk_bus", bus.rk_bus, 0);
    check("reset_strobes", {bus.set_key, bus.set_inv_key}, 0);
    check("reset_flags", {bus.load_done, bus.key_loaded, bus.issue_block, bus.key_ready}, 0);
    rst = 1'b0;
    tick();
    check("reset_ready", bus.key_ready, 1);

    vecs[0] = '{FIPS_KEY, 0, 128'ha0fafe1788542cb123a339392a6c7605, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{FIPS_KEY, 5, 128'ha0fafe1788542cb123a339392a6c7605, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[2] = '{128'h0,   2, 128'h62636363626363636263636362636363, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    for (int i = 0; i < 3; i++) begin
      do_load(vecs[i].key, vecs[i].hold, 1'b0, '0, 1'b0, -1, 0, g1, g10);
      check($sformatf("vec%0d_rk1", i), g1, vecs[i].rk1);
      check($sformatf("vec%0d_rk10", i), g10, vecs[i].rk10);
    end

    repeat (3) tick();
    check("loaded_persists", {bus.key_loaded, bus.issue_block, bus.key_ready}, 3'b101);

    // Second key held on key_valid throughout the first load.
    kb = {$urandom, $urandom, $urandom, $urandom};
    do_load(FIPS_KEY, 0, 1'b1, kb, 1'b0, -1, 0, g1, g10);
    check("held_first_rk10", g10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    do_load(kb, 1, 1'b0, '0, 1'b0, -1, 0, g1, g10);

    do_load(FIPS_KEY, 0, 1'b0, '0, 1'b0, 4, 1, g1, g10);

`ifdef AES_KEY_ZEROIZE_EN
    do_load(FIPS_KEY, 0, 1'b0, '0, 1'b0, 6, 2, g1, g10);
    repeat (2) tick();
    bus.key_in    = FIPS_KEY;
    bus.key_valid = 1'b1;
    bus.zeroize   = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    bus.zeroize   = 1'b0;
    check("zero_beats_valid", {bus.issue_block, bus.set_key}, {1'b0, 11'h7ff});
    tick();
    check("zero_beats_valid_idle", {bus.key_ready, bus.issue_block}, 2'b10);
`endif

    for (int i = 0; i < 6; i++) begin
      kb = {$urandom, $urandom, $urandom, $urandom};
      do_load(kb, int'($urandom_range(0, 3)), 1'b0, '0, 1'b1, -1, 0, g1, g10);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
